// File: rtl/param_set_assoc_cache.sv
// Write-through, no-write-allocate set-associative cache with true-LRU ages.
// A load miss stalls the requester while WORDS in-order memory reads refill the victim way.
module param_set_assoc_cache #(
  parameter int WAYS      = 2,
  parameter int SET_BITS  = 6,
  parameter int WORD_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [15:0] rdata,
  output logic        hit,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << WORD_BITS;
  localparam int TAG_W = 15 - WORD_BITS - SET_BITS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W = WAY_W;
  localparam int CNT_W = WORD_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT} state_t;

  logic [WORD_BITS-1:0] req_word;
  logic [SET_BITS-1:0]  req_set;
  logic [TAG_W-1:0]     req_tag;
  logic                 addr_lsb_unused;

  assign req_word        = req_addr[WORD_BITS:1];
  assign req_set         = req_addr[WORD_BITS+SET_BITS:WORD_BITS+1];
  assign req_tag         = req_addr[15:WORD_BITS+SET_BITS+1];
  assign addr_lsb_unused = req_addr[0];

  logic             valid_q [SETS][WAYS];
  logic             valid_d [SETS][WAYS];
  logic [AGE_W-1:0] age_q   [SETS][WAYS];
  logic [AGE_W-1:0] age_d   [SETS][WAYS];
  logic [TAG_W-1:0] tag_mem [SETS][WAYS];
  logic [15:0]      data_mem[SETS][WAYS][WORDS];

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    recv_cnt_q, recv_cnt_d;
  logic [SET_BITS-1:0] vset_q, vset_d;
  logic [TAG_W-1:0]    vtag_q, vtag_d;
  logic [WAY_W-1:0]    vway_q, vway_d;

  logic [WAYS-1:0]  way_match;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic             victim_found;
  logic             lookup_hit;
  logic             load_miss;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_match
      assign way_match[gi] = valid_q[req_set][gi] && (tag_mem[req_set][gi] == req_tag);
    end
  endgenerate

  assign lookup_hit = req_valid && (state_q == S_IDLE) && (|way_match);
  assign load_miss  = req_valid && !req_write && (state_q == S_IDLE) && !(|way_match);

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_match[w]) hit_way = WAY_W'(w);
    end
  end

  // Prefer an empty way; otherwise the oldest one (age WAYS-1) is the LRU victim.
  always_comb begin
    victim_way   = '0;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_q[req_set][w] && !victim_found) begin
        victim_way   = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[req_set][w] == AGE_W'(WAYS - 1)) victim_way = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      vset_q      <= '0;
      vtag_q      <= '0;
      vway_q      <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      vset_q      <= vset_d;
      vtag_q      <= vtag_d;
      vway_q      <= vway_d;
      valid_q     <= valid_d;
      age_q       <= age_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    vset_d      = vset_q;
    vtag_d      = vtag_q;
    vway_d      = vway_q;
    case (state_q)
      S_IDLE: begin
        if (load_miss) begin
          state_d     = S_FILL;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          vset_d      = req_set;
          vtag_d      = req_tag;
          vway_d      = victim_way;
        end
      end
      S_FILL: begin
        if (issue_cnt_q < CNT_W'(WORDS)) issue_cnt_d = issue_cnt_q + 1'b1;
        if (mem_rvalid) begin
          recv_cnt_d = recv_cnt_q + 1'b1;
          if (recv_cnt_q == CNT_W'(WORDS - 1)) state_d = S_COMMIT;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hit       = lookup_hit;
    rdata     = data_mem[req_set][hit_way][req_word];
    stall     = (state_q != S_IDLE) || load_miss;
    mem_req   = (state_q == S_FILL) && (issue_cnt_q < CNT_W'(WORDS));
    mem_write = (state_q == S_IDLE) && req_valid && req_write;
    mem_addr  = (state_q == S_FILL) ? {vtag_q, vset_q, issue_cnt_q[WORD_BITS-1:0], 1'b0} : req_addr;
    mem_wdata = req_wdata;
  end

  logic                 dw_en;
  logic [SET_BITS-1:0]  dw_set;
  logic [WAY_W-1:0]     dw_way;
  logic [WORD_BITS-1:0] dw_word;
  logic [15:0]          dw_data;

  // Store hits and fill responses share one data write port; they never coincide.
  always_comb begin
    dw_en   = 1'b0;
    dw_set  = req_set;
    dw_way  = hit_way;
    dw_word = req_word;
    dw_data = req_wdata;
    if (lookup_hit && req_write) begin
      dw_en = 1'b1;
    end else if ((state_q == S_FILL) && mem_rvalid) begin
      dw_en   = 1'b1;
      dw_set  = vset_q;
      dw_way  = vway_q;
      dw_word = recv_cnt_q[WORD_BITS-1:0];
      dw_data = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (dw_en) data_mem[dw_set][dw_way][dw_word] <= dw_data;
    if (state_q == S_COMMIT) tag_mem[vset_q][vway_q] <= vtag_q;
  end

  logic                upd_en;
  logic [SET_BITS-1:0] upd_set;
  logic [WAY_W-1:0]    upd_way;
  logic [AGE_W-1:0]    old_age;

  always_comb begin
    upd_en  = lookup_hit || (state_q == S_COMMIT);
    upd_set = (state_q == S_COMMIT) ? vset_q : req_set;
    upd_way = (state_q == S_COMMIT) ? vway_q : hit_way;
    old_age = age_q[upd_set][upd_way];
    valid_d = valid_q;
    age_d   = age_q;
    if (state_q == S_COMMIT) valid_d[vset_q][vway_q] = 1'b1;
    if (upd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == upd_way) begin
          age_d[upd_set][w] = '0;
        end else if (age_q[upd_set][w] < old_age) begin
          age_d[upd_set][w] = age_q[upd_set][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_set_assoc_cache.sv
// Directed bench: a 2-way cache with 3-cycle memory and a 4-way cache with 1-cycle memory.
module tb_param_set_assoc_cache;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_valid, a_write, a_hit, a_stall, a_mem_req, a_mem_write, a_mem_rvalid;
  logic [15:0] a_addr, a_wdata, a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_valid, b_write, b_hit, b_stall, b_mem_req, b_mem_write, b_mem_rvalid;
  logic [15:0] b_addr, b_wdata, b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  param_set_assoc_cache #(.WAYS(2), .SET_BITS(6), .WORD_BITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_write(a_write), .req_addr(a_addr),
    .req_wdata(a_wdata), .rdata(a_rdata), .hit(a_hit), .stall(a_stall), .mem_req(a_mem_req),
    .mem_write(a_mem_write), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_rvalid(a_mem_rvalid)
  );

  param_set_assoc_cache #(.WAYS(4), .SET_BITS(6), .WORD_BITS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_write(b_write), .req_addr(b_addr),
    .req_wdata(b_wdata), .rdata(b_rdata), .hit(b_hit), .stall(b_stall), .mem_req(b_mem_req),
    .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_rvalid(b_mem_rvalid)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  int          qa_due[$];
  logic [15:0] qa_addr[$];
  logic [15:0] alog[$];
  int          qb_due[$];
  logic [15:0] qb_addr[$];
  bit          mem_a_en = 1'b1;

  function automatic logic [15:0] mdata(input logic [15:0] addr);
    return addr ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // In-order memory models: a request seen in cycle t is answered in cycle t+LAT.
  always @(negedge clk) begin
    if (mem_a_en) begin
      a_mem_rvalid = 1'b0;
      if (qa_due.size() > 0 && qa_due[0] <= cyc) begin
        a_mem_rvalid = 1'b1;
        a_mem_rdata  = mdata(qa_addr[0]);
        qa_due.delete(0);
        qa_addr.delete(0);
      end
      if (a_mem_req) begin
        qa_due.push_back(cyc + LAT_A);
        qa_addr.push_back(a_mem_addr);
        alog.push_back(a_mem_addr);
      end
    end
    b_mem_rvalid = 1'b0;
    if (qb_due.size() > 0 && qb_due[0] <= cyc) begin
      b_mem_rvalid = 1'b1;
      b_mem_rdata  = mdata(qb_addr[0]);
      qb_due.delete(0);
      qb_addr.delete(0);
    end
    if (b_mem_req) begin
      qb_due.push_back(cyc + LAT_B);
      qb_addr.push_back(b_mem_addr);
    end
  end

  task automatic load_a(input logic [15:0] addr, output logic h0, output int stalls,
                        output logic h, output logic [15:0] rd);
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b0; a_addr = addr; a_wdata = 16'h0;
    #1;
    h0 = a_hit;
    stalls = 0;
    while (a_stall && stalls < 100) begin
      @(negedge clk); #1;
      stalls++;
    end
    h = a_hit; rd = a_rdata;
    $display("A load  addr=%h first_hit=%0d stalls=%0d hit=%0d rdata=%h", addr, h0, stalls, h, rd);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic load_b(input logic [15:0] addr, output logic h0, output int stalls,
                        output logic h, output logic [15:0] rd);
    @(negedge clk);
    b_valid = 1'b1; b_write = 1'b0; b_addr = addr; b_wdata = 16'h0;
    #1;
    h0 = b_hit;
    stalls = 0;
    while (b_stall && stalls < 100) begin
      @(negedge clk); #1;
      stalls++;
    end
    h = b_hit; rd = b_rdata;
    $display("B load  addr=%h first_hit=%0d stalls=%0d hit=%0d rdata=%h", addr, h0, stalls, h, rd);
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic store_a(input logic [15:0] addr, input logic [15:0] data, output logic h,
                         output logic mw, output logic [15:0] ma, output logic [15:0] md,
                         output logic st, output logic mr);
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b1; a_addr = addr; a_wdata = data;
    #1;
    h = a_hit; mw = a_mem_write; ma = a_mem_addr; md = a_mem_wdata; st = a_stall; mr = a_mem_req;
    $display("A store addr=%h data=%h hit=%0d mem_write=%0d stall=%0d", addr, data, h, mw, st);
    @(negedge clk);
    a_valid = 1'b0; a_write = 1'b0;
  endtask

  logic        h0, h, mw, st, mr;
  logic [15:0] rd, ma, md;
  int          stalls, nlog, rv, guard;

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_write = 1'b0; a_addr = 16'h0; a_wdata = 16'h0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = 16'h0; b_wdata = 16'h0;
    a_mem_rvalid = 1'b0; a_mem_rdata = 16'h0; b_mem_rvalid = 1'b0; b_mem_rdata = 16'h0;
    #2;
    check("rst_a_stall", a_stall, 0);
    check("rst_a_mem_req", a_mem_req, 0);
    check("rst_a_mem_write", a_mem_write, 0);
    check("rst_a_hit", a_hit, 0);
    check("rst_b_stall", b_stall, 0);
    check("rst_b_mem_req", b_mem_req, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Cold fill of 0x1234 through a 3-cycle memory.
    load_a(16'h1234, h0, stalls, h, rd);
    check("cold_first_hit", h0, 0);
    check("cold_stalls", stalls, 13);
    check("cold_hit", h, 1);
    check("cold_rdata", rd, 16'h486E);
    check("cold_req_count", alog.size(), 8);
    check("cold_req_first", alog[0], 16'h1230);
    check("cold_req_last", alog[7], 16'h123E);

    load_a(16'h1236, h0, stalls, h, rd);
    check("neighbour_hit", h0, 1);
    check("neighbour_stalls", stalls, 0);
    check("neighbour_rdata", rd, 16'h486C);

    // Store hit writes through and updates the line.
    store_a(16'h1234, 16'hBEEF, h, mw, ma, md, st, mr);
    check("st_hit", h, 1);
    check("st_mem_write", mw, 1);
    check("st_mem_addr", ma, 16'h1234);
    check("st_mem_wdata", md, 16'hBEEF);
    check("st_stall", st, 0);
    load_a(16'h1234, h0, stalls, h, rd);
    check("st_reload_hit", h0, 1);
    check("st_reload_rdata", rd, 16'hBEEF);

    // Store miss: write-through only, no allocation.
    nlog = alog.size();
    store_a(16'h8000, 16'h1111, h, mw, ma, md, st, mr);
    check("stm_hit", h, 0);
    check("stm_mem_write", mw, 1);
    check("stm_mem_addr", ma, 16'h8000);
    check("stm_stall", st, 0);
    check("stm_mem_req", mr, 0);
    check("stm_req_count", alog.size(), nlog);
    load_a(16'h8000, h0, stalls, h, rd);
    check("stm_load_miss", h0, 0);
    check("stm_load_rdata", rd, 16'hDA5A);

    // Two-way LRU in set 1: A, B, C, A, D -> D replaces C.
    load_a(16'h0010, h0, stalls, h, rd);
    check("lru_A_rdata", rd, 16'h5A4A);
    load_a(16'h0410, h0, stalls, h, rd);
    check("lru_B_miss", h0, 0);
    load_a(16'h0810, h0, stalls, h, rd);
    check("lru_C_miss", h0, 0);
    load_a(16'h0010, h0, stalls, h, rd);
    check("lru_A_again_miss", h0, 0);
    load_a(16'h0C10, h0, stalls, h, rd);
    check("lru_D_miss", h0, 0);
    load_a(16'h0010, h0, stalls, h, rd);
    check("lru_A_after_D_hit", h0, 1);
    load_a(16'h0810, h0, stalls, h, rd);
    check("lru_C_evicted", h0, 0);

    // Four-way LRU in set 1: five tags, the fifth replaces the first.
    load_b(16'h0010, h0, stalls, h, rd);
    check("b_cold_stalls", stalls, 11);
    check("b_cold_rdata", rd, 16'h5A4A);
    load_b(16'h0410, h0, stalls, h, rd);
    load_b(16'h0810, h0, stalls, h, rd);
    load_b(16'h0C10, h0, stalls, h, rd);
    load_b(16'h1010, h0, stalls, h, rd);
    check("b_fifth_miss", h0, 0);
    load_b(16'h0410, h0, stalls, h, rd);
    check("b_tag1_hit", h0, 1);
    load_b(16'h0810, h0, stalls, h, rd);
    check("b_tag2_hit", h0, 1);
    load_b(16'h0C10, h0, stalls, h, rd);
    check("b_tag3_hit", h0, 1);
    check("b_tag3_rdata", rd, 16'h564A);
    load_b(16'h0010, h0, stalls, h, rd);
    check("b_tag0_evicted", h0, 0);

    // Reset after the fourth response of a fill aborts it.
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b0; a_addr = 16'h2000;
    rv = 0; guard = 0;
    while (rv < 4 && guard < 100) begin
      @(negedge clk); #1;
      if (a_mem_rvalid) rv++;
      guard++;
    end
    check("abort_rvalid_seen", rv, 4);
    @(posedge clk); #1;
    rst_n = 1'b0; a_valid = 1'b0; mem_a_en = 1'b0; a_mem_rvalid = 1'b0;
    qa_due.delete(); qa_addr.delete();
    #1;
    check("abort_stall", a_stall, 0);
    check("abort_mem_req", a_mem_req, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    a_mem_rvalid = 1'b1; a_mem_rdata = 16'hDEAD;
    @(negedge clk); #1;
    a_mem_rvalid = 1'b0;
    check("stray_stall", a_stall, 0);
    check("stray_mem_req", a_mem_req, 0);
    mem_a_en = 1'b1;
    load_a(16'h2000, h0, stalls, h, rd);
    check("abort_reload_miss", h0, 0);
    check("abort_reload_stalls", stalls, 13);
    check("abort_reload_rdata", rd, 16'h7A5A);
    load_a(16'h1234, h0, stalls, h, rd);
    check("post_reset_miss", h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
